// File: rtl/fsb_ws.sv
// 68000 bus wait-state / termination generator: DTACK, VPA, optional BERR.
// Define FSB_BERR_TIMEOUT_EN to enable the bus-error timeout counter.
module fsb_ws #(
   parameter int NREADY = 2,
   parameter int MINWS  = 0,
   parameter int TOW    = 8
) (
   input  logic              FCLK,
   input  logic              nRESET,
   input  logic              nAS,
   input  logic [NREADY-1:0] Ready,
   input  logic [NREADY-1:0] RMask,
   input  logic              IACS,
   output logic              nDTACK,
   output logic              nVPA,
   output logic              nBERR,
   output logic              BACT,
   output logic              CACT
);

   if (NREADY < 1 || NREADY > 8) begin : g_nready_chk
      $error("fsb_ws: NREADY out of range 1..8");
   end
   if (MINWS < 0 || MINWS > 7) begin : g_minws_chk
      $error("fsb_ws: MINWS out of range 0..7");
   end
   if (TOW < 4 || TOW > 16) begin : g_tow_chk
      $error("fsb_ws: TOW out of range 4..16");
   end

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      ACK,
      VPA,
      BERR
   } state_t;

   localparam logic [2:0] WSINIT = 3'(MINWS);

   state_t     state_q, state_d;
   logic [2:0] ws_q, ws_d;
   logic       armed_q;
   logic       bact_q;
   logic       cact_q;
   logic       rdy;

`ifdef FSB_BERR_TIMEOUT_EN
   localparam logic [TOW-1:0] TOMAX = {TOW{1'b1}};
   logic [TOW-1:0] to_q, to_d;
`endif

   assign rdy = &(Ready | RMask);

   // armed blocks a cycle start after reset until nAS has been seen high
   always_ff @(posedge FCLK or negedge nRESET) begin
      if (!nRESET) begin
         state_q <= IDLE;
         ws_q    <= '0;
         armed_q <= 1'b0;
         bact_q  <= 1'b0;
         cact_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ws_q    <= ws_d;
         armed_q <= armed_q | nAS;
         bact_q  <= ~nAS;
         cact_q  <= ~nAS & bact_q;
      end
   end

`ifdef FSB_BERR_TIMEOUT_EN
   always_ff @(posedge FCLK or negedge nRESET) begin
      if (!nRESET) begin
         to_q <= '0;
      end else begin
         to_q <= to_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      ws_d    = ws_q;
`ifdef FSB_BERR_TIMEOUT_EN
      to_d    = to_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (!nAS && armed_q) begin
               state_d = WAIT;
               ws_d    = WSINIT;
`ifdef FSB_BERR_TIMEOUT_EN
               to_d    = '0;
`endif
            end
         end
         WAIT: begin
            if (nAS) begin
               state_d = IDLE;
            end else if (ws_q != 3'd0) begin
               ws_d = ws_q - 3'd1;
            end else if (rdy) begin
               state_d = IACS ? VPA : ACK;
            end else begin
`ifdef FSB_BERR_TIMEOUT_EN
               if (to_q == TOMAX) begin
                  state_d = BERR;
               end else begin
                  to_d = to_q + 1'b1;
               end
`endif
            end
         end
         ACK, VPA, BERR: begin
            if (nAS) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign nDTACK = (state_q != ACK);
   assign nVPA   = (state_q != VPA);
`ifdef FSB_BERR_TIMEOUT_EN
   assign nBERR  = (state_q != BERR);
`else
   assign nBERR  = 1'b1;
`endif
   assign BACT   = bact_q;
   assign CACT   = cact_q;

endmodule
